// File: rtl/syn_lb_reg_slave_if.sv
// Local-bus link between the host bridge (master) and a register slave.
interface syn_lb_reg_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              lb_rd_en;
  logic              lb_wr_en;
  logic [ADDR_W-1:0] lb_addr;
  logic [DATA_W-1:0] lb_wr_data;
  logic              lb_wr_valid;
  logic              lb_rd_valid;
  logic [DATA_W-1:0] lb_rd_data;

  modport master (
    output lb_rd_en, lb_wr_en, lb_addr, lb_wr_data,
    input  lb_wr_valid, lb_rd_valid, lb_rd_data
  );

  modport slave (
    input  lb_rd_en, lb_wr_en, lb_addr, lb_wr_data,
    output lb_wr_valid, lb_rd_valid, lb_rd_data
  );
endinterface

// File: rtl/syn_lb_reg_slave.sv
// Local-bus register slave: ID, CTRL, STATUS, sticky EVT (W1C), MASK, SCRATCH.
// Define SYN_LB_REG_SLAVE_ERR_CNT_EN to add the saturating ERR_CNT register at 0x06.
module syn_lb_reg_slave #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 8,
  parameter int          RD_LAT = 1,
  parameter logic [31:0] DEV_ID = 32'h53594E00,
  parameter int          EVT_W  = 8
) (
  input  logic                clk_ir,
  input  logic                rst_il,
  syn_lb_reg_slave_if.slave   lb,
  output logic [DATA_W-1:0]   ctrl_o,
  input  logic [DATA_W-1:0]   status_i,
  input  logic [EVT_W-1:0]    event_i,
  output logic                irq_o
);

  localparam logic [31:0]       UNMAPPED_VAL = 32'hDEADBEEF;
  localparam logic [DATA_W-1:0] ID_VAL       = DEV_ID[DATA_W-1:0];
  localparam logic [DATA_W-1:0] BAD_VAL      = UNMAPPED_VAL[DATA_W-1:0];
  localparam logic [ADDR_W-1:0] A_ID         = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_EVT        = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_MASK       = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_SCRATCH    = ADDR_W'(5);

  logic [DATA_W-1:0] ctrl_q, ctrl_d, scratch_q, scratch_d;
  logic [EVT_W-1:0]  evt_q, evt_d, mask_q, mask_d, evtClr;
  logic              irq_q, wrValid_q;
  logic [31:0]       evtWide, maskWide;
  logic [DATA_W-1:0] rdMux;
  logic              addrMapped, rdAccept;
  logic [RD_LAT-1:0] pipeV_q;
  logic [DATA_W-1:0] pipeD_q [RD_LAT];

  assign evtWide  = 32'(evt_q);
  assign maskWide = 32'(mask_q);
  // A read colliding with a write is dropped; the write still happens.
  assign rdAccept = lb.lb_rd_en & ~lb.lb_wr_en;

`ifdef SYN_LB_REG_SLAVE_ERR_CNT_EN
  localparam logic [ADDR_W-1:0] A_ERRCNT = ADDR_W'(6);
  logic [15:0] errCnt_q, errCnt_d;
  logic [31:0] cntWide;
  logic        errEvent;

  assign cntWide = {16'h0000, errCnt_q};

  // Clear-by-write beats a same-cycle increment; the count saturates at 0xFFFF.
  always_comb begin
    errEvent = (lb.lb_rd_en & lb.lb_wr_en) | ((lb.lb_rd_en | lb.lb_wr_en) & ~addrMapped);
    errCnt_d = errCnt_q;
    if (lb.lb_wr_en && (lb.lb_addr == A_ERRCNT)) begin
      errCnt_d = '0;
    end else if (errEvent && (errCnt_q != 16'hFFFF)) begin
      errCnt_d = errCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_ir) begin
    if (!rst_il) errCnt_q <= '0;
    else         errCnt_q <= errCnt_d;
  end
`endif

  always_comb begin
    rdMux      = BAD_VAL;
    addrMapped = 1'b1;
    case (lb.lb_addr)
      A_ID:      rdMux = ID_VAL;
      A_CTRL:    rdMux = ctrl_q;
      A_STATUS:  rdMux = status_i;
      A_EVT:     rdMux = evtWide[DATA_W-1:0];
      A_MASK:    rdMux = maskWide[DATA_W-1:0];
      A_SCRATCH: rdMux = scratch_q;
`ifdef SYN_LB_REG_SLAVE_ERR_CNT_EN
      A_ERRCNT:  rdMux = cntWide[DATA_W-1:0];
`endif
      default:   addrMapped = 1'b0;
    endcase
  end

  // Event set wins over a same-cycle write-1-to-clear.
  always_comb begin
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    scratch_d = scratch_q;
    evtClr    = '0;
    if (lb.lb_wr_en) begin
      case (lb.lb_addr)
        A_CTRL:    ctrl_d    = lb.lb_wr_data;
        A_EVT:     evtClr    = lb.lb_wr_data[EVT_W-1:0];
        A_MASK:    mask_d    = lb.lb_wr_data[EVT_W-1:0];
        A_SCRATCH: scratch_d = lb.lb_wr_data;
        default:   ;
      endcase
    end
    evt_d = (evt_q & ~evtClr) | event_i;
  end

  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      mask_q    <= '0;
      evt_q     <= '0;
      irq_q     <= 1'b0;
      wrValid_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      mask_q    <= mask_d;
      evt_q     <= evt_d;
      irq_q     <= |(evt_q & mask_q);
      wrValid_q <= lb.lb_wr_en;
    end
  end

  // Data stages load only behind a valid token so the output holds between reads.
  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      pipeV_q <= '0;
      for (int k = 0; k < RD_LAT; k++) pipeD_q[k] <= '0;
    end else begin
      pipeV_q[0] <= rdAccept;
      if (rdAccept) pipeD_q[0] <= rdMux;
      for (int k = 1; k < RD_LAT; k++) begin
        pipeV_q[k] <= pipeV_q[k-1];
        if (pipeV_q[k-1]) pipeD_q[k] <= pipeD_q[k-1];
      end
    end
  end

  assign lb.lb_wr_valid = wrValid_q;
  assign lb.lb_rd_valid = pipeV_q[RD_LAT-1];
  assign lb.lb_rd_data  = pipeD_q[RD_LAT-1];
  assign ctrl_o         = ctrl_q;
  assign irq_o          = irq_q;

endmodule
